ram_reader: RTL and testbench

Request/response front end for the pipelined `ram` block's read port. It accepts tagged read requests on a valid/ready stream and drives the RAM read address. It tracks each in-flight read through the RAM's fixed read latency and buffers the returned data in an output FIFO, so a downstream consumer can apply backpressure without losing data. It sits between hashmap lookup logic and the bucket RAM.

---
 rtl/ram_reader.sv | 96 +++++++++
 tb/tb_ram_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader.sv
// Tagged read front end for a pipelined RAM: tracks reads through the fixed RAM
// latency and buffers returned data in an in-order FIFO with credit-based flow control.
module ram_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_PIPES  = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_val,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [CW-1:0]         outstanding
);
    localparam int L  = NUM_PIPES + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [L-1:0]                vld_pipe_q;
    logic [L-1:0][TAG_WIDTH-1:0] tag_pipe_q;
    logic [DATA_WIDTH-1:0]       data_mem_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]        tag_mem_q  [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               cnt_q, cnt_d, outst_q, outst_d;
    logic                        req_hs, push, pop;

    assign ram_read_addr = req_addr;
    // Ready comes only from the credit register, never from rsp_ready.
    assign req_ready     = (outst_q < CW'(FIFO_DEPTH));
    assign req_hs        = req_valid & req_ready;
    assign push          = vld_pipe_q[L-1];
    assign rsp_valid     = (cnt_q != '0);
    assign pop           = rsp_valid & rsp_ready;
    assign rsp_data      = data_mem_q[rd_ptr_q];
    assign rsp_tag       = tag_mem_q[rd_ptr_q];
    assign outstanding   = outst_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        outst_d  = outst_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({req_hs, pop})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            outst_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= '0;
                tag_mem_q[i]  <= '0;
            end
        end else begin
            // Stage L-1 lines up with the RAM output for the read it describes.
            vld_pipe_q[0] <= req_hs;
            tag_pipe_q[0] <= req_tag;
            for (int i = 1; i < L; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
            if (push) begin
                data_mem_q[wr_ptr_q] <= ram_read_val;
                tag_mem_q[wr_ptr_q]  <= tag_pipe_q[L-1];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
        end
    end
endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: three instances (NUM_PIPES/FIFO_DEPTH = 2/4, 1/4, 0/1), each with
// a behavioural pipelined RAM and a queue scoreboard checked by an independent monitor.
module tb_ram_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic       rv [3];
    logic       rr [3];
    logic       vo [3];
    logic       rdy [3];
    logic [3:0] ra [3];
    logic [3:0] rt [3];
    logic [3:0] to [3];
    logic [7:0] dout [3];
    logic [2:0] outs [3];

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NP = (g == 0) ? 2 : (g == 1) ? 1 : 0;
        localparam int FD = (g == 2) ? 1 : 4;
        localparam int CW = $clog2(FD + 1);

        logic [3:0]    raddr;
        logic [7:0]    rval;
        logic [3:0]    apipe [NP+1];
        logic          v_w, rdy_w;
        logic [7:0]    d_w;
        logic [3:0]    t_w;
        logic [CW-1:0] o_w;

        ram_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TAG_WIDTH(4),
                     .NUM_PIPES(NP), .FIFO_DEPTH(FD)) u (
            .clk(clk), .rst_n(rst_n),
            .req_valid(rv[g]), .req_ready(rdy_w), .req_addr(ra[g]), .req_tag(rt[g]),
            .ram_read_addr(raddr), .ram_read_val(rval),
            .rsp_valid(v_w), .rsp_ready(rr[g]), .rsp_data(d_w), .rsp_tag(t_w),
            .outstanding(o_w));

        assign vo[g]   = v_w;
        assign rdy[g]  = rdy_w;
        assign dout[g] = d_w;
        assign to[g]   = t_w;
        assign outs[g] = 3'(o_w);

        // Behavioural RAM: address register plus NP pipeline stages, contents are read-only here.
        always @(posedge clk) begin
            apipe[0] <= raddr;
            for (int k = 1; k <= NP; k++) apipe[k] <= apipe[k-1];
        end
        assign rval = mem[apipe[NP]];

        logic [11:0] q [$];
        logic [11:0] held;
        logic [11:0] exp_v;
        logic        stall = 1'b0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                stall = 1'b0;
            end else begin
                checks++;
                if (32'(outs[g]) != q.size()) begin
                    errors++;
                    $display("FAIL outstanding%0d: got %0d want %0d", g, outs[g], q.size());
                end
                checks++;
                if (32'(outs[g]) > FD) begin
                    errors++;
                    $display("FAIL overflow%0d: outstanding %0d exceeds depth %0d", g, outs[g], FD);
                end
                if (stall) begin
                    checks++;
                    if (!vo[g] || {dout[g], to[g]} !== held) begin
                        errors++;
                        $display("FAIL stable%0d: got v=%0b %0h want v=1 %0h", g, vo[g], {dout[g], to[g]}, held);
                    end
                end
                if (vo[g]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL stray%0d: got rsp tag %0h want no response", g, to[g]);
                    end else if (rr[g]) begin
                        exp_v = q.pop_front();
                        if ({dout[g], to[g]} !== exp_v) begin
                            errors++;
                            $display("FAIL rsp%0d: got data %0h tag %0h want data %0h tag %0h",
                                     g, dout[g], to[g], exp_v[11:4], exp_v[3:0]);
                        end
                    end
                end
                stall = vo[g] && !rr[g];
                held  = {dout[g], to[g]};
                if (rv[g] && rdy[g]) q.push_back({mem[ra[g]], rt[g]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    initial begin
        int n, acc, first, last, ones, lastacc, mingap;
        logic [39:0] hist;

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
        mem[5] = 8'hA3;
        for (int g = 0; g < 3; g++) begin
            rv[g] = 1'b0; rr[g] = 1'b1; ra[g] = '0; rt[g] = '0;
        end

        // Reset state
        #1 rst_n = 1'b0;
        tick(); tick();
        for (int g = 0; g < 3; g++) begin
            chk("rst_rsp_valid", 32'(vo[g]), 32'd0);
            chk("rst_req_ready", 32'(rdy[g]), 32'd1);
            chk("rst_outstanding", 32'(outs[g]), 32'd0);
            chk("rst_rsp_data", 32'(dout[g]), 32'd0);
            chk("rst_rsp_tag", 32'(to[g]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Single read, L=3: visible 3 edges after accept, consumed at the 4th
        rv[0] = 1'b1; ra[0] = 4'd5; rt[0] = 4'd7;
        chk("single_ready", 32'(rdy[0]), 32'd1);
        tick();
        rv[0] = 1'b0;
        n = 0;
        while (!vo[0] && n < 20) begin tick(); n++; end
        chk("single_latency", 32'(n), 32'd3);
        chk("single_data", 32'(dout[0]), 32'hA3);
        chk("single_tag", 32'(to[0]), 32'd7);
        tick(); tick(); tick();
        chk("single_idle_outs", 32'(outs[0]), 32'd0);
        chk("single_idle_valid", 32'(vo[0]), 32'd0);

        // Back-to-back burst of 16, NUM_PIPES=1, depth 4
        hist = '0;
        for (int c = 0; c < 40; c++) begin
            if (c < 16) begin
                rv[1] = 1'b1; ra[1] = 4'(c); rt[1] = 4'(c);
                chk("burst_ready", 32'(rdy[1]), 32'd1);
            end else rv[1] = 1'b0;
            tick();
            hist[c] = vo[1];
        end
        first = -1; last = -1; ones = 0;
        for (int c = 0; c < 40; c++) if (hist[c]) begin
            if (first < 0) first = c;
            last = c;
            ones++;
        end
        chk("burst_count", 32'(ones), 32'd16);
        chk("burst_contiguous", 32'(last - first + 1), 32'd16);

        // Backpressure: exactly 4 accepts, then credits freed by the first pop
        rr[1] = 1'b0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            rv[1] = 1'b1; ra[1] = 4'(c + 3); rt[1] = 4'(15 - c);
            if (rdy[1]) acc++;
            tick();
        end
        rv[1] = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd4);
        chk("bp_ready_low", 32'(rdy[1]), 32'd0);
        chk("bp_outstanding", 32'(outs[1]), 32'd4);
        rr[1] = 1'b1;
        tick();
        chk("bp_ready_return", 32'(rdy[1]), 32'd1);
        repeat (6) tick();
        chk("bp_drained", 32'(outs[1]), 32'd0);

        // Random valid/ready toggling on all instances
        for (int c = 0; c < 10000; c++) begin
            for (int g = 0; g < 3; g++) begin
                rv[g] = 1'($urandom_range(0, 1));
                ra[g] = 4'($urandom_range(0, 15));
                rt[g] = 4'($urandom_range(0, 15));
                rr[g] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin rv[g] = 1'b0; rr[g] = 1'b1; end
        repeat (12) tick();
        for (int g = 0; g < 3; g++) chk("random_drain", 32'(outs[g]), 32'd0);

        // Reset with two reads in flight and two buffered
        rr[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rv[1] = 1'b1; ra[1] = 4'(c + 8); rt[1] = 4'(c + 1);
            tick();
        end
        rv[1] = 1'b0;
        chk("prerst_outstanding", 32'(outs[1]), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(vo[1]), 32'd0);
        chk("midrst_outstanding", 32'(outs[1]), 32'd0);
        chk("midrst_req_ready", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rr[1] = 1'b1;
        repeat (8) tick();
        chk("postrst_valid", 32'(vo[1]), 32'd0);
        chk("postrst_outstanding", 32'(outs[1]), 32'd0);

        // Depth 1, NUM_PIPES=0, continuous requests: never more than one accept per 2 cycles
        acc = 0; lastacc = -1; mingap = 99;
        for (int c = 0; c < 30; c++) begin
            rv[2] = 1'b1; ra[2] = 4'(c); rt[2] = 4'(c + 2);
            if (rdy[2]) begin
                if (lastacc >= 0 && c - lastacc < mingap) mingap = c - lastacc;
                lastacc = c;
                acc++;
            end
            tick();
        end
        rv[2] = 1'b0;
        chk("depth1_min_gap_ge2", 32'(mingap >= 2), 32'd1);
        chk("depth1_progress", 32'(acc >= 10), 32'd1);
        repeat (6) tick();
        chk("depth1_drained", 32'(outs[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
